// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// spi_reg_ctrl : SPI burst register sequencer with an 8-bit control bank and
//                fixed-priority arbitration against one internal requester.
// Revision 1.0
// ============================================================================
module spi_reg_ctrl #(
  parameter logic [7:0] FPGA_VER = 8'hC2,
  parameter int         NUM_REGS = 8
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       spi_begin,
  input  logic       spi_rx_avail,
  input  logic [7:0] spi_rx_byte,
  output logic [7:0] spi_tx_byte,
  input  logic       int_req,
  input  logic       int_we,
  input  logic [6:0] int_addr,
  input  logic [7:0] int_wdata,
  output logic       int_gnt,
  output logic [7:0] int_rdata,
  output logic       bootloader_force,
  output logic [7:0] uart_inverted,
  output logic [7:0] telem_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_rx_q1;
  logic       r_rx_q2;
  logic       r_rw;
  logic [6:0] r_addr;
  logic       r_force_bt;
  logic [7:0] r_uart_inv;
  logic [7:0] r_telem;
  logic [7:0] r_scratch;
  logic [7:0] r_err_cnt;

  logic       w_rx_stb;
  logic       w_spi_data;
  logic       w_spi_access;
  logic       w_spi_wr;
  logic       w_int_grant;
  logic       w_we;
  logic       w_writable;
  logic [6:0] w_waddr;
  logic [7:0] w_wdata;

  function automatic logic [7:0] bank_rd(input logic [6:0] a);
    case (a)
      7'h00:   bank_rd = FPGA_VER;
      7'h01:   bank_rd = {7'd0, r_force_bt};
      7'h02:   bank_rd = r_uart_inv;
      7'h03:   bank_rd = r_telem;
      7'h04:   bank_rd = r_scratch;
      7'h05:   bank_rd = r_err_cnt;
      default: bank_rd = 8'h00;
    endcase
  endfunction

  assign w_rx_stb     = r_rx_q1 & ~r_rx_q2;
  assign w_spi_data   = w_rx_stb & ~spi_begin & (r_state == DATA);
  // An address byte only touches the bank when it opens a read burst.
  assign w_spi_access = w_spi_data |
                        (w_rx_stb & ~spi_begin & (r_state == ADDR) & ~spi_rx_byte[7]);
  assign w_spi_wr     = w_spi_data & r_rw;
  // A granted requester may still be asserting in the grant cycle; skip it.
  assign w_int_grant  = int_req & ~w_spi_access & ~int_gnt;

  assign w_we       = w_spi_wr | (w_int_grant & int_we);
  assign w_waddr    = w_spi_wr ? r_addr : int_addr;
  assign w_wdata    = w_spi_wr ? spi_rx_byte : int_wdata;
  assign w_writable = (int'(w_waddr) < NUM_REGS) && (w_waddr >= 7'h01) && (w_waddr <= 7'h04);

  always_ff @(posedge clk_core) begin
    if (reset) begin
      r_state          <= IDLE;
      r_rx_q1          <= 1'b0;
      r_rx_q2          <= 1'b0;
      r_rw             <= 1'b0;
      r_addr           <= 7'd0;
      r_force_bt       <= 1'b0;
      r_uart_inv       <= 8'h00;
      r_telem          <= 8'h00;
      r_scratch        <= 8'h00;
      r_err_cnt        <= 8'h00;
      spi_tx_byte      <= 8'h00;
      int_gnt          <= 1'b0;
      int_rdata        <= 8'h00;
      bootloader_force <= 1'b0;
      uart_inverted    <= 8'h00;
      telem_sel        <= 8'h00;
    end else begin
      r_rx_q1          <= spi_rx_avail;
      r_rx_q2          <= r_rx_q1;
      int_gnt          <= w_int_grant;
      bootloader_force <= r_force_bt;
      uart_inverted    <= r_uart_inv;
      telem_sel        <= r_telem;

      if (w_int_grant) begin
        int_rdata <= bank_rd(int_addr);
      end

      if (w_we) begin
        if (w_writable) begin
          case (w_waddr)
            7'h01:   r_force_bt <= w_wdata[0];
            7'h02:   r_uart_inv <= w_wdata;
            7'h03:   r_telem    <= w_wdata;
            default: r_scratch  <= w_wdata;
          endcase
        end else if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end

      if (spi_begin) begin
        r_state     <= ADDR;
        spi_tx_byte <= 8'h00;
      end else if (w_rx_stb) begin
        case (r_state)
          ADDR: begin
            r_rw        <= spi_rx_byte[7];
            r_addr      <= spi_rx_byte[6:0];
            spi_tx_byte <= spi_rx_byte[7] ? 8'h00 : bank_rd(spi_rx_byte[6:0]);
            r_state     <= DATA;
          end
          DATA: begin
            r_addr      <= r_addr + 7'd1;
            spi_tx_byte <= r_rw ? 8'h00 : bank_rd(r_addr + 7'd1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_ctrl : directed + randomized bench against a register-map model.
// Revision 1.0
// ============================================================================
module tb_spi_reg_ctrl;

  logic       clk_core = 1'b0;
  logic       reset = 1'b1;
  logic       spi_begin = 1'b0;
  logic       spi_rx_avail = 1'b0;
  logic [7:0] spi_rx_byte = 8'h00;
  logic [7:0] spi_tx_byte;
  logic       int_req = 1'b0;
  logic       int_we = 1'b0;
  logic [6:0] int_addr = 7'd0;
  logic [7:0] int_wdata = 8'h00;
  logic       int_gnt;
  logic [7:0] int_rdata;
  logic       bootloader_force;
  logic [7:0] uart_inverted;
  logic [7:0] telem_sel;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: register contents by address, plus transaction context.
  logic [7:0] m_bank [0:127];
  int         m_err;
  int         m_state;   // 0 idle, 1 expecting address, 2 data phase
  int         m_addr;
  bit         m_rw;
  logic [7:0] m_tx;

  spi_reg_ctrl #(.FPGA_VER(8'hC2), .NUM_REGS(8)) dut (
    .clk_core(clk_core), .reset(reset),
    .spi_begin(spi_begin), .spi_rx_avail(spi_rx_avail), .spi_rx_byte(spi_rx_byte),
    .spi_tx_byte(spi_tx_byte),
    .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_gnt(int_gnt), .int_rdata(int_rdata),
    .bootloader_force(bootloader_force), .uart_inverted(uart_inverted),
    .telem_sel(telem_sel)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  function automatic logic [7:0] m_rd(input int a);
    if (a == 5) return m_err[7:0];
    return m_bank[a];
  endfunction

  function automatic void m_wr(input int a, input logic [7:0] d);
    if (a >= 1 && a <= 4) m_bank[a] = (a == 1) ? {7'd0, d[0]} : d;
    else if (m_err < 255) m_err++;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 128; i++) m_bank[i] = 8'h00;
    m_bank[0] = 8'hC2;
    m_err = 0; m_state = 0; m_addr = 0; m_rw = 0; m_tx = 8'h00;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (m_state == 1) begin
      m_rw = b[7]; m_addr = int'(b[6:0]);
      m_tx = m_rw ? 8'h00 : m_rd(m_addr);
      m_state = 2;
    end else if (m_state == 2) begin
      if (m_rw) m_wr(m_addr, b);
      m_addr = (m_addr + 1) % 128;
      m_tx = m_rw ? 8'h00 : m_rd(m_addr);
    end
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".force"}, {31'd0, bootloader_force}, {31'd0, m_bank[1][0]});
    check({tag, ".uinv"}, {24'd0, uart_inverted}, {24'd0, m_bank[2]});
    check({tag, ".telem"}, {24'd0, telem_sel}, {24'd0, m_bank[3]});
  endtask

  task automatic spi_start();
    spi_begin = 1'b1;
    tick();
    spi_begin = 1'b0;
    m_state = 1; m_tx = 8'h00;
  endtask

  // Byte rises, strobe two edges later; tx checked right after the action edge.
  task automatic send_byte(input string tag, input logic [7:0] b);
    spi_rx_byte = b; spi_rx_avail = 1'b1;
    tick();
    tick();
    m_byte(b);
    check({tag, ".tx"}, {24'd0, spi_tx_byte}, {24'd0, m_tx});
    spi_rx_avail = 1'b0;
    tick();
    tick();
  endtask

  task automatic int_access(input string tag, input bit we, input logic [6:0] a,
                            input logic [7:0] d);
    bit got = 0;
    logic [7:0] exp_rd;
    int_req = 1'b1; int_we = we; int_addr = a; int_wdata = d;
    exp_rd = m_rd(int'(a));
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (int_gnt) got = 1;
    end
    int_req = 1'b0;
    check({tag, ".gnt"}, {31'd0, got}, 32'd1);
    if (got) begin
      if (we) m_wr(int'(a), d);
      else check({tag, ".rdata"}, {24'd0, int_rdata}, {24'd0, exp_rd});
    end
    tick();
  endtask

  initial begin
    m_reset();
    tick();
    tick();
    reset = 1'b0;
    check("rst.tx", {24'd0, spi_tx_byte}, 32'h00);
    check("rst.gnt", {31'd0, int_gnt}, 32'd0);
    check("rst.rdata", {24'd0, int_rdata}, 32'h00);
    check_outs("rst");

    // Version and error counter after reset
    spi_start(); send_byte("t1.ver", 8'h00);
    spi_start(); send_byte("t1.err", 8'h05);

    // Write burst then read-back burst
    spi_start();
    send_byte("t2.wa", 8'h81); send_byte("t2.w1", 8'h01);
    send_byte("t2.w2", 8'hA5); send_byte("t2.w3", 8'h3C);
    check_outs("t2");
    spi_start();
    send_byte("t2.ra", 8'h01); send_byte("t2.r1", 8'h00); send_byte("t2.r2", 8'h00);

    // Write to read-only version, then saturation of the error counter
    spi_start(); send_byte("t3.wa", 8'h80); send_byte("t3.wd", 8'h55);
    spi_start(); send_byte("t3.ver", 8'h00);
    spi_start(); send_byte("t3.err1", 8'h05);
    for (int i = 0; i < 256; i++) begin
      spi_start(); send_byte("t3.sa", 8'h80); send_byte("t3.sd", 8'(i));
    end
    spi_start(); send_byte("t3.errsat", 8'h05);
    check("t3.model_sat", 32'(m_err), 32'd255);

    // Internal write colliding with an SPI data strobe
    spi_start(); send_byte("t4.wa", 8'h83);
    spi_rx_byte = 8'h12; spi_rx_avail = 1'b1;
    tick();
    int_req = 1'b1; int_we = 1'b1; int_addr = 7'h04; int_wdata = 8'h77;
    tick();
    m_byte(8'h12);
    check("t4.tx", {24'd0, spi_tx_byte}, {24'd0, m_tx});
    check("t4.gnt_blocked", {31'd0, int_gnt}, 32'd0);
    tick();
    check("t4.gnt_late", {31'd0, int_gnt}, 32'd1);
    int_req = 1'b0;
    m_wr(4, 8'h77);
    spi_rx_avail = 1'b0;
    tick(); tick();
    check_outs("t4");
    spi_start(); send_byte("t4.ra", 8'h04);

    // Abort a write burst right after its address byte
    spi_start(); send_byte("t5.wa", 8'h82);
    spi_start();
    check("t5.abort_tx", {24'd0, spi_tx_byte}, 32'h00);
    send_byte("t5.ra", 8'h02);
    check_outs("t5");

    // Randomized bursts interleaved with internal accesses
    for (int t = 0; t < 40; t++) begin
      logic [7:0] ab;
      int len;
      ab = 8'($urandom);
      if ($urandom_range(0, 3) != 0) ab[6:0] = 7'($urandom_range(0, 9));
      len = $urandom_range(1, 4);
      spi_start();
      send_byte("rnd.a", ab);
      for (int k = 0; k < len; k++) send_byte("rnd.d", 8'($urandom));
      check_outs("rnd");
      if ($urandom_range(0, 1) == 1)
        int_access("rnd.int", bit'($urandom_range(0, 1)), 7'($urandom_range(0, 8)),
                   8'($urandom));
    end
    int_access("int.rd_err", 1'b0, 7'h05, 8'h00);

    // Read wrap from 0x7F, then reset mid-burst
    spi_start();
    send_byte("t6.r7f", 8'h7F);
    send_byte("t6.wrap", 8'h00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    tick();
    check("t6.tx", {24'd0, spi_tx_byte}, 32'h00);
    check("t6.gnt", {31'd0, int_gnt}, 32'd0);
    check("t6.rdata", {24'd0, int_rdata}, 32'h00);
    check_outs("t6");
    send_byte("t6.ignored", 8'h00);
    spi_begin = 1'b1;
    tick();
    spi_begin = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_byte("t6.ignored2", 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
